// File: rtl/rob_unit.sv
// rtl/rob_unit.sv - circular reorder buffer: allocate, write-back, in-order retire, lookup, flush
module rob_unit #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd_in,
  input  logic                      issue_is_branch,
  input  logic                      issue_pred_taken,
  input  logic [31:0]               issue_alt_pc,
  input  logic                      issue_done,
  input  logic [31:0]               issue_value,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [4:0]                issue_rd,
  input  logic                      wb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]               wb_value,
  input  logic                      wb_taken,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
  output logic [31:0]               get_value1,
  output logic [31:0]               get_value2,
  output logic                      get_ready1,
  output logic                      get_ready2,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic                      flush,
  output logic [31:0]               flush_pc
);
  localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] FULL_COUNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  logic [DEPTH-1:0]          busy, ready, is_branch, pred_taken, taken;
  logic [4:0]                rd_q     [DEPTH];
  logic [31:0]               value_q  [DEPTH];
  logic [31:0]               alt_pc_q [DEPTH];
  logic [ROB_SIZE_WIDTH-1:0] head, tail;
  logic [ROB_SIZE_WIDTH:0]   count;
  logic                      alloc, retire, mispredict;
  logic                      hit1, hit2;

  assign rob_full     = (count == FULL_COUNT);
  assign alloc        = issue_valid && !rob_full && !flush;
  assign issue_rob_id = tail;
  assign issue_rd     = alloc ? issue_rd_in : 5'd0;

  assign retire     = busy[head] && ready[head] && !flush;
  assign mispredict = retire && is_branch[head] && (taken[head] != pred_taken[head]);

  // Same-cycle write-back bypasses the stored entry so consumers never miss a result.
  assign hit1       = wb_valid && (wb_rob_id == ask_rob_id1);
  assign hit2       = wb_valid && (wb_rob_id == ask_rob_id2);
  assign get_value1 = hit1 ? wb_value : value_q[ask_rob_id1];
  assign get_value2 = hit2 ? wb_value : value_q[ask_rob_id2];
  assign get_ready1 = hit1 || ready[ask_rob_id1];
  assign get_ready2 = hit2 || ready[ask_rob_id2];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      ready         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      flush         <= 1'b0;
      flush_pc      <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        ready     <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        commit_rd <= '0;
        flush     <= 1'b0;
      end else begin
        commit_rd <= '0;
        flush     <= 1'b0;
        if (wb_valid && busy[wb_rob_id]) begin
          ready[wb_rob_id]   <= 1'b1;
          value_q[wb_rob_id] <= wb_value;
          taken[wb_rob_id]   <= wb_taken;
        end
        if (retire) begin
          commit_rob_id <= head;
          commit_value  <= value_q[head];
          commit_rd     <= is_branch[head] ? 5'd0 : rd_q[head];
          busy[head]    <= 1'b0;
          ready[head]   <= 1'b0;
          head          <= head + 1'b1;
          if (mispredict) begin
            flush    <= 1'b1;
            flush_pc <= alt_pc_q[head];
          end
        end
        // Allocation is written last so it wins over a write-back to the same id.
        if (alloc) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= issue_done;
          value_q[tail]    <= issue_value;
          rd_q[tail]       <= issue_rd_in;
          is_branch[tail]  <= issue_is_branch;
          pred_taken[tail] <= issue_pred_taken;
          taken[tail]      <= issue_pred_taken;
          alt_pc_q[tail]   <= issue_alt_pc;
          tail             <= tail + 1'b1;
        end
        if (alloc && !retire)
          count <= count + 1'b1;
        else if (!alloc && retire)
          count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rob_unit.sv
// tb/tb_rob_unit.sv - self-checking bench for rob_unit: vector table, corner sequences, random vs queue model
module tb_rob_unit;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_is_branch, issue_pred_taken, issue_done;
  logic [4:0]  issue_rd_in;
  logic [31:0] issue_alt_pc, issue_value;
  logic        rob_full;
  logic [2:0]  issue_rob_id;
  logic [4:0]  issue_rd;
  logic        wb_valid, wb_taken;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_value;
  logic [2:0]  ask_rob_id1, ask_rob_id2;
  logic [31:0] get_value1, get_value2;
  logic        get_ready1, get_ready2;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] flush_pc;

  rob_unit #(.ROB_SIZE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd_in(issue_rd_in), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc), .issue_done(issue_done),
    .issue_value(issue_value), .rob_full(rob_full), .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_taken(wb_taken),
    .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
    .get_value1(get_value1), .get_value2(get_value2), .get_ready1(get_ready1), .get_ready2(get_ready2),
    .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a queue of in-flight instructions, oldest first.
  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] val;
    logic        br;
    logic        pred;
    logic        tk;
    logic [31:0] alt;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  logic [4:0]  m_crd;
  logic [2:0]  m_crid;
  logic [31:0] m_cval;
  logic        m_flush;
  logic [31:0] m_fpc;

  task automatic model_reset();
    q.delete();
    m_tail = 0; m_crd = 0; m_crid = 0; m_cval = 0; m_flush = 0; m_fpc = 0;
  endtask

  task automatic lookup_chk(string name, logic [2:0] ask, logic act_r, logic [31:0] act_v);
    if (wb_valid && wb_rob_id == ask) begin
      chk({name, "_ready_bypass"}, 32'(act_r), 32'd1);
      chk({name, "_value_bypass"}, act_v, wb_value);
    end else begin
      foreach (q[i]) if (q[i].id == ask) begin
        chk({name, "_ready"}, 32'(act_r), 32'(q[i].done));
        chk({name, "_value"}, act_v, q[i].val);
      end
    end
  endtask

  task automatic model_check();
    logic full_m, alloc_m;
    full_m  = (q.size() == 8);
    alloc_m = issue_valid && !full_m && !m_flush;
    chk("rob_full", 32'(rob_full), 32'(full_m));
    chk("issue_rob_id", 32'(issue_rob_id), 32'(m_tail));
    chk("issue_rd", 32'(issue_rd), alloc_m ? 32'(issue_rd_in) : 32'd0);
    chk("commit_rd", 32'(commit_rd), 32'(m_crd));
    chk("flush", 32'(flush), 32'(m_flush));
    if (m_flush) chk("flush_pc", flush_pc, m_fpc);
    if (m_crd != 0 || m_flush) begin
      chk("commit_rob_id", 32'(commit_rob_id), 32'(m_crid));
      chk("commit_value", commit_value, m_cval);
    end
    lookup_chk("get1", ask_rob_id1, get_ready1, get_value1);
    lookup_chk("get2", ask_rob_id2, get_ready2, get_value2);
  endtask

  task automatic model_update();
    logic go;
    ent_t e;
    if (rst) begin model_reset(); return; end
    if (!rdy) return;
    if (m_flush) begin
      q.delete(); m_tail = 0; m_crd = 0; m_flush = 0;
      return;
    end
    go = (q.size() > 0) && q[0].done;
    m_crd = 0;
    if (go) begin
      m_crid = q[0].id;
      m_cval = q[0].val;
      m_crd  = q[0].br ? 5'd0 : q[0].rd;
      if (q[0].br && q[0].tk != q[0].pred) begin
        m_flush = 1;
        m_fpc   = q[0].alt;
      end
    end
    if (wb_valid) foreach (q[i]) if (q[i].id == wb_rob_id) begin
      q[i].done = 1; q[i].val = wb_value; q[i].tk = wb_taken;
    end
    if (go) void'(q.pop_front());
    if (issue_valid && q.size() + (go ? 1 : 0) < 8) begin
      e = '{id: 3'(m_tail), rd: issue_rd_in, done: issue_done, val: issue_value, br: issue_is_branch,
            pred: issue_pred_taken, tk: issue_pred_taken, alt: issue_alt_pc};
      q.push_back(e);
      m_tail = (m_tail + 1) % 8;
    end
  endtask

  task automatic idle_inputs();
    rdy = 1; issue_valid = 0; issue_rd_in = 0; issue_is_branch = 0; issue_pred_taken = 0;
    issue_alt_pc = 0; issue_done = 0; issue_value = 0; wb_valid = 0; wb_rob_id = 0;
    wb_value = 0; wb_taken = 0; ask_rob_id1 = 0; ask_rob_id2 = 0;
  endtask

  task automatic step();
    #1;
    model_check();
    model_update();
    @(negedge clk);
  endtask

  task automatic issue(logic [4:0] rd, logic done, logic [31:0] val);
    issue_valid = 1; issue_rd_in = rd; issue_done = done; issue_value = val;
  endtask

  typedef struct {
    logic iv; logic [4:0] rd; logic done; logic [31:0] val; logic br; logic pred; logic [31:0] alt;
    logic wv; logic [2:0] wid; logic [31:0] wval; logic wt; logic [2:0] ask; logic chk_get;
    logic e_full; logic [2:0] e_id; logic [4:0] e_ird; logic [4:0] e_crd; logic [2:0] e_crid;
    logic [31:0] e_cval; logic e_flush; logic [31:0] e_fpc; logic e_gr; logic [31:0] e_gv;
  } vec_t;

  vec_t vecs[14];
  int   seen[$];

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      #1;
      chk("reset_full", 32'(rob_full), 32'd0);
      chk("reset_id", 32'(issue_rob_id), 32'd0);
      chk("reset_commit_rd", 32'(commit_rd), 32'd0);
      chk("reset_flush", 32'(flush), 32'd0);
      step();
    end

    // Basic issue/write-back/commit, then a mispredicted branch with younger entries.
    vecs[0]  = '{iv: 1, rd: 5, e_id: 0, e_ird: 5, default: 0};
    vecs[1]  = '{wv: 1, wid: 0, wval: 32'h1234, chk_get: 1, e_id: 1, e_gr: 1, e_gv: 32'h1234, default: 0};
    vecs[2]  = '{chk_get: 1, e_id: 1, e_gr: 1, e_gv: 32'h1234, default: 0};
    vecs[3]  = '{e_id: 1, e_crd: 5, e_crid: 0, e_cval: 32'h1234, default: 0};
    vecs[4]  = '{e_id: 1, default: 0};
    vecs[5]  = '{iv: 1, br: 1, alt: 32'h100, e_id: 1, default: 0};
    vecs[6]  = '{iv: 1, rd: 3, done: 1, val: 7, e_id: 2, e_ird: 3, default: 0};
    vecs[7]  = '{iv: 1, rd: 3, done: 1, val: 8, e_id: 3, e_ird: 3, default: 0};
    vecs[8]  = '{wv: 1, wid: 1, wval: 32'haa, wt: 1, e_id: 4, default: 0};
    vecs[9]  = '{e_id: 4, default: 0};
    vecs[10] = '{iv: 1, rd: 9, wv: 1, wid: 2, wval: 32'h55, e_id: 4, e_crid: 1, e_cval: 32'haa,
                 e_flush: 1, e_fpc: 32'h100, default: 0};
    vecs[11] = '{e_id: 0, default: 0};
    vecs[12] = '{e_id: 0, default: 0};
    vecs[13] = '{e_id: 0, default: 0};
    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      issue_valid = vecs[i].iv; issue_rd_in = vecs[i].rd; issue_done = vecs[i].done;
      issue_value = vecs[i].val; issue_is_branch = vecs[i].br; issue_pred_taken = vecs[i].pred;
      issue_alt_pc = vecs[i].alt; wb_valid = vecs[i].wv; wb_rob_id = vecs[i].wid;
      wb_value = vecs[i].wval; wb_taken = vecs[i].wt;
      ask_rob_id1 = vecs[i].ask; ask_rob_id2 = vecs[i].ask;
      #1;
      chk($sformatf("vec%0d_full", i), 32'(rob_full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_issue_rob_id", i), 32'(issue_rob_id), 32'(vecs[i].e_id));
      chk($sformatf("vec%0d_issue_rd", i), 32'(issue_rd), 32'(vecs[i].e_ird));
      chk($sformatf("vec%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].e_crd));
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      if (vecs[i].e_crd != 0 || vecs[i].e_flush) begin
        chk($sformatf("vec%0d_commit_rob_id", i), 32'(commit_rob_id), 32'(vecs[i].e_crid));
        chk($sformatf("vec%0d_commit_value", i), commit_value, vecs[i].e_cval);
      end
      if (vecs[i].e_flush) chk($sformatf("vec%0d_flush_pc", i), flush_pc, vecs[i].e_fpc);
      if (vecs[i].chk_get) begin
        chk($sformatf("vec%0d_get_ready1", i), 32'(get_ready1), 32'(vecs[i].e_gr));
        chk($sformatf("vec%0d_get_value1", i), get_value1, vecs[i].e_gv);
      end
      step();
    end

    // Fill all 8 entries, refuse a 9th, complete out of order, expect in-order retirement.
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); issue(5'(i + 1), 0, 32'(i * 16)); step();
    end
    idle_inputs(); issue(5'd20, 0, 32'h0);
    #1;
    chk("full_after_8", 32'(rob_full), 32'd1);
    chk("ninth_issue_rd", 32'(issue_rd), 32'd0);
    chk("ninth_tail", 32'(issue_rob_id), 32'd0);
    step();
    for (int i = 7; i >= 0; i--) begin
      idle_inputs(); wb_valid = 1; wb_rob_id = 3'(i); wb_value = 32'h1000 + 32'(i); step();
    end
    seen.delete();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      #1;
      if (commit_rd != 0) seen.push_back(int'(commit_rob_id));
      step();
    end
    chk("inorder_count", 32'(seen.size()), 32'd8);
    foreach (seen[i]) chk($sformatf("inorder_id%0d", i), 32'(seen[i]), 32'(i));
    #1;
    chk("tail_wrapped", 32'(issue_rob_id), 32'd0);
    idle_inputs();

    // Full ROB: a same-cycle commit does not free a slot for that cycle's issue.
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); issue(5'(i + 1), 0, 32'(i)); step();
    end
    idle_inputs(); wb_valid = 1; wb_rob_id = 0; wb_value = 32'h77; step();
    idle_inputs(); issue(5'd17, 1, 32'h99);
    #1;
    chk("full_commit_refused", 32'(issue_rd), 32'd0);
    chk("full_commit_still_full", 32'(rob_full), 32'd1);
    step();
    idle_inputs(); issue(5'd17, 1, 32'h99);
    #1;
    chk("next_cycle_accept", 32'(issue_rd), 32'd17);
    chk("next_cycle_id", 32'(issue_rob_id), 32'd0);
    step();
    for (int i = 1; i < 8; i++) begin
      idle_inputs(); wb_valid = 1; wb_rob_id = 3'(i); wb_value = 32'(i); step();
    end
    idle_inputs();
    for (int c = 0; c < 12; c++) step();

    // rdy low holds a ready head in place.
    idle_inputs(); issue(5'd4, 1, 32'h4444); step();
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); rdy = 0;
      #1;
      chk($sformatf("stall%0d_commit_rd", c), 32'(commit_rd), 32'd0);
      step();
    end
    idle_inputs(); step();
    idle_inputs();
    #1;
    chk("after_stall_commit_rd", 32'(commit_rd), 32'd4);
    chk("after_stall_commit_value", commit_value, 32'h4444);
    step();

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        issue(5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0), $urandom);
        issue_is_branch = ($urandom_range(0, 3) == 0);
        issue_pred_taken = 1'($urandom_range(0, 1));
        issue_alt_pc = $urandom;
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1; wb_rob_id = q[$urandom_range(0, q.size() - 1)].id;
      end else if ($urandom_range(0, 9) == 0) begin
        wb_valid = 1; wb_rob_id = 3'($urandom_range(0, 7));
      end
      wb_value = $urandom; wb_taken = 1'($urandom_range(0, 1));
      ask_rob_id1 = 3'($urandom_range(0, 7)); ask_rob_id2 = 3'($urandom_range(0, 7));
      step();
    end

    // Reset after traffic returns everything to idle.
    idle_inputs(); rst = 1; step();
    rst = 0;
    #1;
    chk("rereset_full", 32'(rob_full), 32'd0);
    chk("rereset_id", 32'(issue_rob_id), 32'd0);
    chk("rereset_commit_rd", 32'(commit_rd), 32'd0);
    chk("rereset_flush", 32'(flush), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_unit.md
Name: rob_unit

Overview:
- Circular reorder buffer that allocates ROB ids to issued instructions and collects write-back results.
- Retires instructions in order, one per cycle, and drives the register file's commit port.
- Sits between the Decoder/issue logic (upstream) and the register file (downstream).
- Also answers the register file's combinational ROB-id lookups, and raises a one-cycle flush on branch misprediction.

Parameters:
ROB_SIZE_WIDTH, 3, log2 of entry count; depth = 2^ROB_SIZE_WIDTH (8).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
rdy  in  1  global enable; when low, no state changes.
issue_valid  in  1  Decoder presents an instruction this cycle.
issue_rd_in  in  5  destination register; 0 means no register write.
issue_is_branch  in  1  entry is a conditional branch.
issue_pred_taken  in  1  predicted direction of the branch.
issue_alt_pc  in  32  PC to fetch from if the prediction proves wrong.
issue_done  in  1  result already known at issue (e.g. LUI/JAL).
issue_value  in  32  result when issue_done=1.
rob_full  out  1  no free entry; the Decoder must not issue.
issue_rob_id  out  ROB_SIZE_WIDTH  id being allocated (current tail).
issue_rd  out  5  issue_rd_in when an allocation occurs, else 0.
wb_valid  in  1  CDB write-back strobe.
wb_rob_id  in  ROB_SIZE_WIDTH  entry being completed.
wb_value  in  32  result value.
wb_taken  in  1  actual branch outcome (ignored for non-branches).
ask_rob_id1 / ask_rob_id2  in  ROB_SIZE_WIDTH  lookup ids from the register file.
get_value1 / get_value2  out  32  value of the looked-up entry.
get_ready1 / get_ready2  out  1  looked-up entry has its result.
commit_rob_id  out  ROB_SIZE_WIDTH  id of the retiring entry.
commit_rd  out  5  register to write; 0 means no commit this cycle.
commit_value  out  32  value to write.
flush  out  1  one-cycle misprediction flush pulse.
flush_pc  out  32  redirect PC, valid while flush=1.

Behaviour:
- Storage:
  - Per entry: busy, ready, rd, value, is_branch, pred_taken, alt_pc.
  - Pointers: head, tail (ROB_SIZE_WIDTH bits, natural wrap 7->0).
  - count: ROB_SIZE_WIDTH+1 bits.
- Reset (rst=1 at edge): all busy/ready cleared, head=tail=count=0; commit_rd=0, commit_rob_id=0, commit_value=0, flush=0, flush_pc=0. Reset overrides everything, including a mid-flush cycle.
- rdy=0: no state or register-output change.
- Allocation (combinational):
  - alloc = issue_valid && !rob_full && !flush.
  - issue_rob_id = tail.
  - issue_rd = alloc ? issue_rd_in : 0.
  - rob_full = (count == 2^ROB_SIZE_WIDTH), taken from the registered count only; a same-cycle commit does not free a slot for that cycle's issue.
- Allocation (at edge, when alloc):
  - Entry[tail] is written: busy=1, ready=issue_done, value=issue_value, plus the branch fields.
  - tail increments; count increments.
- Write-back: wb_valid on a busy entry sets ready=1 and stores value and wb_taken (the actual outcome). wb_valid to a non-busy entry is ignored. If write-back and allocation target the same id in one cycle, allocation wins.
- Lookup (combinational): get_valueN = entry value; get_readyN = entry ready. Same-cycle bypass: if wb_valid && wb_rob_id==ask_rob_idN, return wb_value with ready=1.
- Commit (at edge): when head entry is busy && ready and flush=0:
  - commit_rob_id <= head; commit_value <= value.
  - commit_rd <= rd for a non-branch; 0 for a branch.
  - busy is cleared; head increments; count decrements.
  - Otherwise commit_rd <= 0.
  - commit_* are registered, so they lag the head becoming ready by one edge. An entry written back at edge N commits (outputs visible) after edge N+1.
- Simultaneous allocate and commit: count is unchanged.
- Misprediction: head is a ready branch with actual != pred_taken.
  - It commits with commit_rd=0.
  - flush <= 1 and flush_pc <= alt_pc for exactly one cycle.
  - At the following edge (flush=1), all entries are cleared, head=tail=count=0, and any issue or write-back in that cycle is dropped.
  - A correct branch retires silently.
- Empty (count=0): no commit; commit_rd=0.

Test Plan:
- Reset then idle → rob_full=0, issue_rob_id=0, commit_rd=0, flush=0 for 10 cycles.
- Issue rd=5, issue_done=0 at id 0; wb id0 value 0x1234 → same cycle get_ready1=1 / get_value1=0x1234 via bypass for ask id0; next edge commit_rob_id=0, commit_rd=5, commit_value=0x1234 for one cycle.
- Issue 8 instructions without write-back → rob_full=1 after the 8th, and a 9th issue_valid gives issue_rd=0 with tail unchanged. Write back ids in order 7..0 → commits still emerge in order 0..7, one per cycle. The tail wraps to 0 for the next issue.
- Issue branch pred_taken=0, alt_pc=0x100, followed by two rd=3 instructions; wb branch taken=1 → commit_rd=0 and flush=1 with flush_pc=0x100 for one cycle; afterwards count=0, issue_rob_id=0, and the rd=3 entries never commit.
- With the ROB full, commit and issue_valid in the same cycle → issue refused that cycle (issue_rd=0) and accepted the next cycle.
- rdy=0 for 3 cycles with a ready head → commit outputs unchanged; the commit occurs after rdy returns to 1.
